// File: rtl/tester_gtx_frm_rx.sv
// Receive-side frame checker for a GTX lane tester: acquires word sync on idle
// characters, then checks SOF/payload/EOF framing, the payload ramp and sequence bytes.
module tester_gtx_frm_rx #(
  parameter logic [15:0] IDLE     = 16'hBC50,
  parameter int          SYNC_CNT = 16,
  parameter int          LOS_CNT  = 4
) (
  input  logic        usrclk,
  input  logic        usrrst_n,
  input  logic [15:0] rx_data,
  input  logic [1:0]  rx_char,
  input  logic        cnt_clr,
  output logic        sync,
  output logic        frm_done,
  output logic        frm_good,
  output logic [2:0]  err_code,
  output logic        code_err,
  output logic [15:0] frm_cnt,
  output logic [15:0] err_cnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_UNSYNC   = 2'd0,
    ST_IDLE     = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_EOF_WAIT = 2'd3
  } state_t;

  localparam int SYNC_W = $clog2(SYNC_CNT + 1);
  localparam int LOS_W  = $clog2(LOS_CNT + 1);
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_CNT - 1);
  localparam logic [LOS_W-1:0]  LOS_LAST  = LOS_W'(LOS_CNT - 1);

  // Code 1 (code error) is reported through code_err, never as a frame result.
  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_LEN   = 3'd2;
  localparam logic [2:0] E_DATA  = 3'd3;
  localparam logic [2:0] E_SEQ   = 3'd4;
  localparam logic [2:0] E_TRUNC = 3'd5;

  state_t            state, state_nxt;
  logic [SYNC_W-1:0] idle_cnt, idle_cnt_nxt;
  logic [LOS_W-1:0]  los_cnt, los_cnt_nxt;
  logic [7:0]        len, len_nxt;
  logic [7:0]        idx, idx_nxt;
  logic [7:0]        exp_seq, exp_seq_nxt;
  logic              data_err, data_err_nxt;
  logic              first_eof, first_eof_nxt;
  logic              done_d, cerr_d;
  logic [2:0]        code_d;

  logic [7:0] hi, lo;
  logic       w_idle, w_sof, w_eof, w_pay, w_ill;
  logic       los_hit, seq_bad, pay_ok, last_pay;

  assign hi = rx_data[15:8];
  assign lo = rx_data[7:0];

  assign w_idle = (rx_char == 2'b10) && (rx_data == IDLE);
  assign w_sof  = (rx_char == 2'b10) && (hi == 8'hFB) && !w_idle;
  assign w_eof  = (rx_char == 2'b10) && (hi == 8'hFD) && !w_idle;
  assign w_pay  = (rx_char == 2'b00);
  assign w_ill  = !(w_idle || w_sof || w_eof || w_pay);

  assign los_hit  = (state != ST_UNSYNC) && w_ill && (los_cnt == LOS_LAST);
  assign seq_bad  = !first_eof && (lo != exp_seq);
  assign pay_ok   = (rx_data == {8'h00, idx});
  assign last_pay = (idx == len - 8'd1);

  assign dbg_state = state;

  always_ff @(posedge usrclk or negedge usrrst_n) begin
    if (!usrrst_n) state <= ST_UNSYNC;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    idle_cnt_nxt  = '0;
    los_cnt_nxt   = '0;
    len_nxt       = len;
    idx_nxt       = idx;
    data_err_nxt  = data_err;
    first_eof_nxt = first_eof;
    exp_seq_nxt   = exp_seq;
    if (state != ST_UNSYNC && w_ill && !los_hit) los_cnt_nxt = los_cnt + LOS_W'(1);
    case (state)
      ST_UNSYNC: begin
        if (w_idle) begin
          if (idle_cnt == SYNC_LAST) begin
            state_nxt     = ST_IDLE;
            first_eof_nxt = 1'b1;
          end else begin
            idle_cnt_nxt = idle_cnt + SYNC_W'(1);
          end
        end
      end
      ST_IDLE: begin
        if (w_sof && lo != 8'h00) begin
          len_nxt      = lo;
          idx_nxt      = 8'h00;
          data_err_nxt = 1'b0;
          state_nxt    = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (w_pay) begin
          if (!pay_ok) data_err_nxt = 1'b1;
          if (last_pay) state_nxt = ST_EOF_WAIT;
          else          idx_nxt   = idx + 8'd1;
        end else if (w_sof && lo != 8'h00) begin
          // The interrupting SOF opens the next frame straight away.
          len_nxt      = lo;
          idx_nxt      = 8'h00;
          data_err_nxt = 1'b0;
        end else begin
          state_nxt = ST_IDLE;
          if (w_eof) begin
            exp_seq_nxt   = lo + 8'd1;
            first_eof_nxt = 1'b0;
          end
        end
      end
      ST_EOF_WAIT: begin
        state_nxt = ST_IDLE;
        if (w_eof) begin
          exp_seq_nxt   = lo + 8'd1;
          first_eof_nxt = 1'b0;
        end
      end
      default: state_nxt = ST_UNSYNC;
    endcase
    if (los_hit) state_nxt = ST_UNSYNC;
  end

  // frm_done is a valid-only strobe with no back-pressure; frm_good and err_code qualify it.
  always_comb begin
    done_d = 1'b0;
    cerr_d = 1'b0;
    code_d = E_NONE;
    case (state)
      ST_IDLE: begin
        if (w_sof && lo == 8'h00) begin
          done_d = 1'b1;
          code_d = E_LEN;
        end else if (!w_idle && !w_sof) begin
          cerr_d = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (!w_pay) begin
          done_d = 1'b1;
          code_d = w_eof ? E_LEN : E_TRUNC;
        end
      end
      ST_EOF_WAIT: begin
        done_d = 1'b1;
        if (!w_eof)        code_d = E_LEN;
        else if (seq_bad)  code_d = E_SEQ;
        else if (data_err) code_d = E_DATA;
        else               code_d = E_NONE;
      end
      default: ;
    endcase
    if (los_hit && (state == ST_PAYLOAD || state == ST_EOF_WAIT)) begin
      done_d = 1'b1;
      code_d = E_TRUNC;
    end
  end

  always_ff @(posedge usrclk or negedge usrrst_n) begin
    if (!usrrst_n) begin
      idle_cnt  <= '0;
      los_cnt   <= '0;
      len       <= 8'h00;
      idx       <= 8'h00;
      exp_seq   <= 8'h00;
      data_err  <= 1'b0;
      first_eof <= 1'b0;
    end else begin
      idle_cnt  <= idle_cnt_nxt;
      los_cnt   <= los_cnt_nxt;
      len       <= len_nxt;
      idx       <= idx_nxt;
      exp_seq   <= exp_seq_nxt;
      data_err  <= data_err_nxt;
      first_eof <= first_eof_nxt;
    end
  end

  always_ff @(posedge usrclk or negedge usrrst_n) begin
    if (!usrrst_n) begin
      sync     <= 1'b0;
      frm_done <= 1'b0;
      frm_good <= 1'b0;
      err_code <= 3'd0;
      code_err <= 1'b0;
      frm_cnt  <= 16'h0000;
      err_cnt  <= 16'h0000;
    end else begin
      sync     <= (state_nxt != ST_UNSYNC);
      frm_done <= done_d;
      frm_good <= done_d && (code_d == E_NONE);
      err_code <= done_d ? code_d : E_NONE;
      code_err <= cerr_d;
      if (cnt_clr) begin
        frm_cnt <= 16'h0000;
        err_cnt <= 16'h0000;
      end else begin
        if (done_d && code_d == E_NONE && frm_cnt != 16'hFFFF)
          frm_cnt <= frm_cnt + 16'd1;
        if (((done_d && code_d != E_NONE) || cerr_d) && err_cnt != 16'hFFFF)
          err_cnt <= err_cnt + 16'd1;
      end
    end
  end

endmodule
